in_mapper_pq: RTL
=================

Name: in_mapper_pq

Overview:
Parametrised successor of the AER-to-SpiNNaker input mapper. Converts AER events into SpiNNaker multicast (MC) packets with a runtime key prefix and odd parity. Buffers packets in a depth-parametrised circular FIFO. Has a programmable SpiNNaker-stall timeout with dump mode, a saturating dropped-event counter and a FIFO level output. Sits between the AER input front-end and spinn_driver in spinn_neu_if_lib.

Parameters:
AER_WIDTH, 32, width of iaer_data; legal range 1..32.
FIFO_DEPTH, 4, packet FIFO entries; any value >= 2, not limited to powers of two.
TO_WIDTH, 16, width of the dump timeout and its counter.

Ports:
clk  in  1  single clock; all logic on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
cfg_key_prefix  in  32  bits OR-ed above the AER field; bits [AER_WIDTH-1:0] ignored.
cfg_dump_timeout  in  TO_WIDTH  cycles without ipkt_rdy before dump mode; 0 disables dump.
cfg_cnt_clr  in  1  synchronous clear of drop_cnt.
dump_mode  out  1  registered; 1 while dumping.
drop_cnt  out  32  saturating count of discarded events.
fifo_level  out  clog2(FIFO_DEPTH+1)  current occupancy.
iaer_data  in  AER_WIDTH  event address.
iaer_vld  in  1  event valid.
iaer_rdy  out  1  event accepted when iaer_vld & iaer_rdy.
ipkt_data  out  72  packet {payload[71:40], key[39:8], ctrl[7:0]}.
ipkt_vld  out  1  packet valid.
ipkt_rdy  in  1  downstream accepts when ipkt_vld & ipkt_rdy.

Behaviour:
- Reset values:
  - dump_mode=0, drop_cnt=0, fifo_level=0, ipkt_vld=0, iaer_rdy=1.
  - Timeout counter is loaded with cfg_dump_timeout on the first clock after reset.
  - FIFO contents are don't-care.
- Key and control:
  - key = {cfg_key_prefix[31:AER_WIDTH], iaer_data}; prefix is sampled in the write cycle.
  - ctrl[7:2]=0 (MC type); ctrl[1]=payload flag; ctrl[0]=parity.
  - Parity is chosen so the XOR of all 72 bits of ipkt_data is 1 (odd). It is computed at write time and stored.
- FIFO (circular buffer):
  - Read pointer, write pointer and count. Pointers wrap at FIFO_DEPTH-1 -> 0.
  - write = iaer_vld & ~full. read = ipkt_rdy & ~empty.
  - Simultaneous write and read: count unchanged, both pointers advance.
  - A write when full is never performed, even if a read occurs in the same cycle (no pass-through).
  - First-word fall-through: ipkt_vld = ~empty; ipkt_data = mem[rd_ptr].
  - Latency: an event accepted at edge N is presented on ipkt_vld after edge N. It can be read at edge N+1 at the earliest.
  - Order is preserved.
- Dump FSM, states RUN and DUMP:
  - Counter reloads with cfg_dump_timeout whenever ipkt_rdy=1.
  - Otherwise the counter decrements while nonzero.
  - RUN->DUMP when the counter = 0, ipkt_rdy = 0 and cfg_dump_timeout != 0. dump_mode rises on that edge.
  - DUMP->RUN on the edge after ipkt_rdy=1.
  - cfg_dump_timeout=0 holds RUN permanently.
- iaer_rdy = ~full | dump_mode.
  - In DUMP with the FIFO not full, events are still buffered.
  - In DUMP with the FIFO full, events are accepted and discarded.
- drop_cnt:
  - Increments on each discarded event and saturates at 32'hFFFF_FFFF.
  - cfg_cnt_clr has priority over increment.
  - Buffered contents are never flushed by dump mode.
- Asserting rst_n low mid-operation empties the FIFO immediately (asynchronous) and discards any queued packets.

Optional Feature:
- Macro IN_MAPPER_TIMESTAMP_EN.
- When defined:
  - A 32-bit free-running, wrapping counter, reset to 0, is captured into the payload at the write cycle.
  - ctrl[1]=1; FIFO width is 72 bits.
- When undefined:
  - payload=32'h0 and ctrl[1]=0; FIFO stores 40 bits.
  - No timestamp counter is synthesised.

Decomposition:
- Shared package spinn_pkt_pkg holds:
  - constants for the MC type code, control bit positions (PAR_BIT=0, PLD_BIT=1), key/payload field offsets and the 72-bit packet width;
  - a parity helper function.
- One natural sub-module: pkt_fifo, a parametrised circular FWFT FIFO with level output, reused by the out_mapper successor.

Test Plan:
1. Reset with AER_WIDTH=16 and cfg_key_prefix=32'hABCD_0000; send iaer_data=16'h1234 with ipkt_rdy=1 -> next cycle ipkt_data[39:8]=32'hABCD1234, ctrl[1]=0, odd parity over 72 bits.
2. FIFO_DEPTH=4, ipkt_rdy=0, cfg_dump_timeout=100; send 6 events -> 4 accepted, iaer_rdy=0 afterwards, fifo_level=4; drain in order.
3. cfg_dump_timeout=8, ipkt_rdy held 0 with a full FIFO -> dump_mode=1 after 9 cycles; 10 further events -> drop_cnt=10; one ipkt_rdy pulse -> dump_mode=0 and oldest packet read.
4. Full FIFO, simultaneous iaer_vld and ipkt_rdy -> read only, fifo_level 4->3, next cycle write accepted.
5. cfg_dump_timeout=0, ipkt_rdy=0 for 1000 cycles -> dump_mode stays 0, drop_cnt=0.
6. With IN_MAPPER_TIMESTAMP_EN, events written 5 cycles apart -> payloads differ by 5, ctrl[1]=1; assert rst_n mid-burst -> ipkt_vld=0 immediately.

Source files
------------

// File: rtl/spinn_pkt_pkg.sv
// Shared SpiNNaker packet definitions: field offsets, control bit positions,
// the multicast type code, the dump FSM state type and the parity helper.
package spinn_pkt_pkg;

  // Full packet is {payload[71:40], key[39:8], ctrl[7:0]}
  localparam int PKT_WIDTH  = 72;
  localparam int CTRL_WIDTH = 8;
  localparam int KEY_WIDTH  = 32;
  localparam int PLD_WIDTH  = 32;
  localparam int CTRL_LSB   = 0;
  localparam int KEY_LSB    = 8;
  localparam int PLD_LSB    = 40;

  // Control byte layout
  localparam int PAR_BIT = 0;
  localparam int PLD_BIT = 1;
  localparam logic [5:0] MC_TYPE = 6'b00_0000;

  // Stall watchdog states of the input mapper
  typedef enum logic {
    RUN  = 1'b0,
    DUMP = 1'b1
  } dump_state_t;

  // Returns the parity bit that makes the XOR over the whole packet equal 1,
  // given a packet whose parity bit position is still 0.
  function automatic logic odd_parity(input logic [PKT_WIDTH-1:0] pkt);
    return ~(^pkt);
  endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Parametrised circular first-word-fall-through FIFO with occupancy output.
// Depth need not be a power of two; pointers wrap explicitly at DEPTH-1.
// Writes while full and reads while empty are ignored internally.
module pkt_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           rd_en,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [LVL_W-1:0] count;
  logic             do_wr;
  logic             do_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // A full FIFO never takes a write, even when a read frees a slot that cycle
  assign full    = (count == FULL_LVL);
  assign empty   = (count == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign level   = count;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset empties the buffer at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_rd) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care after reset so it has none
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/in_mapper_pq.sv
// AER-to-SpiNNaker input mapper: builds multicast packets with a runtime key
// prefix and odd parity, queues them in pkt_fifo, and dumps incoming events
// when the SpiNNaker side stalls longer than a programmable timeout.
// Optional macro IN_MAPPER_TIMESTAMP_EN adds a 32-bit timestamp payload.
module in_mapper_pq
  import spinn_pkt_pkg::*;
#(
  parameter int AER_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TO_WIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [31:0]                       cfg_key_prefix,
  input  logic [TO_WIDTH-1:0]               cfg_dump_timeout,
  input  logic                              cfg_cnt_clr,
  output logic                              dump_mode,
  output logic [31:0]                       drop_cnt,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  input  logic [AER_WIDTH-1:0]              iaer_data,
  input  logic                              iaer_vld,
  output logic                              iaer_rdy,
  output logic [PKT_WIDTH-1:0]              ipkt_data,
  output logic                              ipkt_vld,
  input  logic                              ipkt_rdy
);

  // Ones over the AER field; the prefix only contributes bits above it
  localparam logic [31:0] AER_MASK = 32'((64'd1 << AER_WIDTH) - 64'd1);

`ifdef IN_MAPPER_TIMESTAMP_EN
  localparam int FIFO_W = PKT_WIDTH;
`else
  localparam int FIFO_W = KEY_WIDTH + CTRL_WIDTH;
`endif

  logic [KEY_WIDTH-1:0]  key;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic [FIFO_W-1:0]     wr_data;
  logic [FIFO_W-1:0]     rd_data;
  logic                  full;
  logic                  empty;
  logic                  wr_en;
  logic                  rd_en;
  logic                  drop;
  dump_state_t           state;
  logic [TO_WIDTH-1:0]   to_cnt;
  logic                  to_loaded;

  assign key = (cfg_key_prefix & ~AER_MASK) | 32'(iaer_data);

`ifdef IN_MAPPER_TIMESTAMP_EN
  logic [PLD_WIDTH-1:0] ts_cnt;

  // Free-running wrapping timestamp, captured into each packet at write time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
    end
  end

  // Control byte with payload flag set; parity covers the timestamp as well
  always_comb begin
    ctrl                     = '0;
    ctrl[CTRL_WIDTH-1:2]     = MC_TYPE;
    ctrl[PLD_BIT]            = 1'b1;
    ctrl[PAR_BIT]            = odd_parity({ts_cnt, key, ctrl});
  end

  assign wr_data   = {ts_cnt, key, ctrl};
  assign ipkt_data = rd_data;
`else
  // Control byte without payload; parity is taken over a zero payload
  always_comb begin
    ctrl                     = '0;
    ctrl[CTRL_WIDTH-1:2]     = MC_TYPE;
    ctrl[PLD_BIT]            = 1'b0;
    ctrl[PAR_BIT]            = odd_parity({PLD_WIDTH'(0), key, ctrl});
  end

  assign wr_data   = {key, ctrl};
  assign ipkt_data = {PLD_WIDTH'(0), rd_data};
`endif

  // Handshakes: while dumping the mapper never back-pressures the AER side
  assign wr_en    = iaer_vld & ~full;
  assign rd_en    = ipkt_rdy & ~empty;
  assign drop     = iaer_vld & full & dump_mode;
  assign iaer_rdy = ~full | dump_mode;
  assign ipkt_vld = ~empty;

  pkt_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  // Stall watchdog: counter reloads on ipkt_rdy and counts down otherwise;
  // dump mode starts when it has run out and ends once SpiNNaker takes data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      dump_mode <= 1'b0;
      to_cnt    <= '0;
      to_loaded <= 1'b0;
    end else begin
      to_loaded <= 1'b1;
      if (!to_loaded || ipkt_rdy) begin
        to_cnt <= cfg_dump_timeout;
      end else if (to_cnt != '0) begin
        to_cnt <= to_cnt - TO_WIDTH'(1);
      end
      case (state)
        RUN: begin
          if (to_loaded && !ipkt_rdy && (to_cnt == '0) &&
              (cfg_dump_timeout != '0)) begin
            state     <= DUMP;
            dump_mode <= 1'b1;
          end
        end
        DUMP: begin
          if (ipkt_rdy || (cfg_dump_timeout == '0)) begin
            state     <= RUN;
            dump_mode <= 1'b0;
          end
        end
        default: begin
          state     <= RUN;
          dump_mode <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of events discarded in dump mode; clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (cfg_cnt_clr) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 32'hFFFF_FFFF)) begin
      drop_cnt <= drop_cnt + 32'd1;
    end
  end

endmodule
